// File: rtl/tt_scan_pkg.sv
// Shared types and constants for the truth-table scanner: FSM states,
// table geometry and the repeating per-vector dwell pattern.
package tt_scan_pkg;

    localparam int N_IN    = 4;
    localparam int TBL_W   = 2 ** N_IN;
    localparam int DWELL_W = 4;

    localparam logic [DWELL_W-1:0] DWELL0 = 4'd7;
    localparam logic [DWELL_W-1:0] DWELL1 = 4'd2;
    localparam logic [DWELL_W-1:0] DWELL2 = 4'd9;
    localparam logic [DWELL_W-1:0] DWELL3 = 4'd4;

    localparam logic [DWELL_W-1:0] DWELL_ONE = 4'd1;
    localparam logic [DWELL_W-1:0] DWELL_TWO = 4'd2;

    localparam logic [DWELL_W-1:0] DWELL_TAB [4] = '{DWELL0, DWELL1, DWELL2, DWELL3};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        FIN   = 2'd2
    } scan_state_e;

    function automatic logic [DWELL_W-1:0] dwell_of(input logic [1:0] idx);
        return DWELL_TAB[idx];
    endfunction

endpackage

// File: rtl/tt_scanner_if.sv
// Bundle between the scanner and its surroundings: scan control/result
// signals plus the stimulus/response pair wired to the lab circuit.
interface tt_scanner_if;
    import tt_scan_pkg::*;

    logic              start;
    logic [TBL_W-1:0]  expected_i;
    logic              z_i;
    logic [N_IN-1:0]   vec_o;
    logic              busy;
    logic              done;
    logic [TBL_W-1:0]  table_o;
    logic              match;
    logic [TBL_W-1:0]  glitch_o;

    modport master (
        output start, expected_i, z_i,
        input  vec_o, busy, done, table_o, match, glitch_o
    );

    modport slave (
        input  start, expected_i, z_i,
        output vec_o, busy, done, table_o, match, glitch_o
    );

endinterface

// File: rtl/tt_dwell_cnt.sv
// Loadable down-counter timing how long each input vector is held.
// Load wins over decrement; the count never wraps below zero.
module tt_dwell_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         zero
);

    logic [W-1:0] cnt_r;

    // Counter register: load a fresh dwell, else step down while enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {W{1'b0}};
        end else if (load) begin
            cnt_r <= load_val;
        end else if (dec && (cnt_r != {W{1'b0}})) begin
            cnt_r <= cnt_r - {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt  = cnt_r;
    assign zero = (cnt_r == {W{1'b0}});

endmodule

// File: rtl/tt_scanner.sv
// Walks the 4-input lab circuit through all vectors, captures Z into a truth
// table and compares it to a golden table. TT_SCAN_GLITCH_CHECK_EN adds per-vector Z stability flags.
module tt_scanner
    import tt_scan_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    tt_scanner_if.slave bus
);

    scan_state_e        state_r, state_nxt_s;
    logic [N_IN-1:0]    vec_r, vec_nxt_s;
    logic [TBL_W-1:0]   table_r, table_nxt_s;
    logic               busy_r, busy_nxt_s;
    logic               done_r, done_nxt_s;
    logic               match_r, match_nxt_s;
    logic [TBL_W-1:0]   glitch_nxt_s;

    logic               cnt_load_s;
    logic [DWELL_W-1:0] cnt_load_val_s;
    logic               cnt_dec_s;
    logic [DWELL_W-1:0] cnt_s;
    logic               cnt_zero_s;
    logic               last_vec_s;

    assign last_vec_s = (vec_r == {N_IN{1'b1}});
    assign cnt_dec_s  = (state_r == DRIVE) && (cnt_s != {DWELL_W{1'b0}});

    tt_dwell_cnt #(
        .W (DWELL_W)
    ) u_dwell_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load_s),
        .load_val (cnt_load_val_s),
        .dec      (cnt_dec_s),
        .cnt      (cnt_s),
        .zero     (cnt_zero_s)
    );

`ifdef TT_SCAN_GLITCH_CHECK_EN
    logic [TBL_W-1:0]   glitch_r;
    logic               zref_r, zref_nxt_s;
    logic [DWELL_W-1:0] dwell_cur_s;

    assign dwell_cur_s = dwell_of(vec_r[1:0]);

    // Glitch tracking: reference Z taken on dwell cycle 2, any later difference flags the vector.
    always_comb begin
        zref_nxt_s   = zref_r;
        glitch_nxt_s = glitch_r;
        if ((state_r == IDLE) && bus.start) begin
            glitch_nxt_s = {TBL_W{1'b0}};
        end else if (state_r == DRIVE) begin
            if ((dwell_cur_s >= DWELL_TWO) && (cnt_s == (dwell_cur_s - DWELL_TWO))) begin
                zref_nxt_s = bus.z_i;
            end else if ((dwell_cur_s > DWELL_TWO) && (cnt_s < (dwell_cur_s - DWELL_TWO))
                         && (bus.z_i != zref_r)) begin
                glitch_nxt_s[vec_r] = 1'b1;
            end else begin
                zref_nxt_s = zref_r;
            end
        end else begin
            glitch_nxt_s = glitch_r;
        end
    end

    // Glitch flag and reference-sample registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            glitch_r <= {TBL_W{1'b0}};
            zref_r   <= 1'b0;
        end else begin
            glitch_r <= glitch_nxt_s;
            zref_r   <= zref_nxt_s;
        end
    end

    assign bus.glitch_o = glitch_r;
`else
    assign glitch_nxt_s = {TBL_W{1'b0}};
    assign bus.glitch_o = {TBL_W{1'b0}};
`endif

    // Next-state and datapath decode; match is taken from the next table so it lines up with done.
    always_comb begin
        state_nxt_s    = state_r;
        vec_nxt_s      = vec_r;
        table_nxt_s    = table_r;
        busy_nxt_s     = busy_r;
        done_nxt_s     = 1'b0;
        match_nxt_s    = match_r;
        cnt_load_s     = 1'b0;
        cnt_load_val_s = {DWELL_W{1'b0}};
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    state_nxt_s    = DRIVE;
                    vec_nxt_s      = {N_IN{1'b0}};
                    table_nxt_s    = {TBL_W{1'b0}};
                    busy_nxt_s     = 1'b1;
                    match_nxt_s    = 1'b0;
                    cnt_load_s     = 1'b1;
                    cnt_load_val_s = dwell_of(2'd0) - DWELL_ONE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            DRIVE: begin
                if (cnt_zero_s) begin
                    table_nxt_s[vec_r] = bus.z_i;
                    if (last_vec_s) begin
                        state_nxt_s = FIN;
                        busy_nxt_s  = 1'b0;
                        done_nxt_s  = 1'b1;
                        match_nxt_s = (table_nxt_s == bus.expected_i)
                                      && (glitch_nxt_s == {TBL_W{1'b0}});
                    end else begin
                        vec_nxt_s      = vec_r + {{(N_IN-1){1'b0}}, 1'b1};
                        cnt_load_s     = 1'b1;
                        cnt_load_val_s = dwell_of(vec_nxt_s[1:0]) - DWELL_ONE;
                    end
                end else begin
                    state_nxt_s = DRIVE;
                end
            end
            FIN: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Registered scan outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_r   <= {N_IN{1'b0}};
            table_r <= {TBL_W{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            match_r <= 1'b0;
        end else begin
            vec_r   <= vec_nxt_s;
            table_r <= table_nxt_s;
            busy_r  <= busy_nxt_s;
            done_r  <= done_nxt_s;
            match_r <= match_nxt_s;
        end
    end

    assign bus.vec_o   = vec_r;
    assign bus.table_o = table_r;
    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.match   = match_r;

endmodule

// File: doc/tt_scanner.md
Name: tt_scanner

Overview:
- Sequential stimulus/capture stage wrapped around the 4-input combinational lab circuit (inputs M,N,P,Q, output Z).
- Upstream side: walks the input vector 0000→1111 using a repeating per-vector dwell pattern of 7,2,9,4 cycles.
- Downstream side: samples Z on the last cycle of each dwell, builds a 16-bit truth table, and compares it against an expected table.
- Lets the lab circuit run on-board self-checked, without a simulator testbench.

Parameters:
- N_IN, 4, number of DUT inputs; table width is 2**N_IN.
- DWELL0, 7, dwell cycles for vectors with vec[1:0]==0.
- DWELL1, 2, dwell cycles for vec[1:0]==1.
- DWELL2, 9, dwell cycles for vec[1:0]==2.
- DWELL3, 4, dwell cycles for vec[1:0]==3.
- DWELL_W, 4, dwell counter width; every DWELLx must be in 1..2**DWELL_W-1.

Ports:
- clk, in, 1, single system clock; all state updates on the rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, one-cycle request to begin a scan; sampled only in IDLE.
- expected_i, in, 2**N_IN, golden truth table; bit k is the expected Z for vector k. Sampled at the DONE transition.
- z_i, in, 1, DUT output Z.
- vec_o, out, N_IN, DUT input vector; bit3=M, bit2=N, bit1=P, bit0=Q. Registered.
- busy, out, 1, high in DRIVE.
- done, out, 1, one-cycle pulse when the scan completes.
- table_o, out, 2**N_IN, captured truth table; bit k is Z sampled for vector k.
- match, out, 1, table_o==expected_i. Valid from the done pulse until the next start.
- glitch_o, out, 2**N_IN, per-vector instability flags (see Optional Feature).

Behaviour:
- Reset values (asynchronous on rst_n=0):
  - state=IDLE.
  - vec_o=0, busy=0, done=0, table_o=0, match=0, glitch_o=0.
  - Dwell counter = 0.
- States are IDLE, DRIVE, FIN.
- IDLE:
  - Outputs hold their last values; vec_o holds.
  - start=1 → DRIVE, with vec_o←0, cnt←DWELL0-1, table_o←0, glitch_o←0, match←0.
- DRIVE:
  - While cnt!=0: cnt decrements each cycle.
  - When cnt==0: table_o[vec_o]←z_i (last cycle of the dwell).
    - If vec_o==2**N_IN-1 → FIN.
    - Else vec_o increments and cnt←DWELL[(vec_o+1)[1:0]]-1.
- Dwell: each vector is driven for exactly DWELLx cycles.
  - Full scan = 4*(7+2+9+4) = 88 cycles in DRIVE.
  - With start asserted at cycle 0, done is high at cycle 89.
- FIN:
  - Single cycle: done=1, match←(table_o==expected_i), then → IDLE.
  - The compare uses the final table including the last sample; implement it as a next-state compare or with a one-cycle-late done. In either case, done and a valid match must coincide.
- start while busy or in FIN: ignored, with no restart.
- start in the same cycle that FIN returns to IDLE: ignored. The next cycle's start is accepted.
- vec_o wraps only through restart, never by overflow; an increment past 2**N_IN-1 is unreachable.
- rst_n asserted mid-scan: immediate return to the reset values; a partial table is discarded.
- Table bits are written only at dwell end; z_i is ignored on all other cycles (unless the feature is enabled).

Optional Feature:
- Macro: TT_SCAN_GLITCH_CHECK_EN.
- Defined:
  - Per vector, z_i is recorded at cycle 2 of the dwell. Cycle 1 is DUT settle and is not checked.
  - If z_i differs from that recorded value on any later cycle of the same dwell, glitch_o[vec_o]←1.
  - Dwells of 1 or 2 cycles are never flagged.
  - If any glitch bit is set at FIN, match is forced to 0.
- Undefined: glitch_o tied to 0; no extra flops.

Decomposition:
- Package tt_scan_pkg holds:
  - The state enum (IDLE, DRIVE, FIN).
  - N_IN default.
  - A localparam dwell array {7,2,9,4}.
  - A function dwell_of(idx[1:0]).
- One natural sub-module, tt_dwell_cnt:
  - Loadable down-counter with load, load_val, zero output.
  - Instantiated once.

Test Plan:
1. DUT model Z=M&N&P&Q, expected_i=16'h8000, start pulse → vec_o steps 0..15 with dwells 7,2,9,4 repeating; done at cycle 89; table_o=16'h8000; match=1.
2. DUT model Z=M^Q, expected_i=16'h55AA but true table 16'h55AA with bit 3 flipped in expected_i → table_o=16'h55AA, match=0.
3. Start re-pulsed at cycles 10 and 50 during a scan → no restart; vec_o sequence and done timing identical to scenario 1.
4. rst_n low for 1 cycle while vec_o=5 → all outputs 0 immediately; a new start yields a full 88-cycle scan and a correct table.
5. Back-to-back: start in the cycle after done → second scan begins; table_o cleared to 0 on acceptance, then rebuilt identically.
6. With TT_SCAN_GLITCH_CHECK_EN, DUT toggles Z once at cycle 5 of vector 8's dwell → glitch_o=16'h0100, match=0 despite expected_i equal to table_o.
